uart_rx_deserializer: RTL and testbench

Parametrised UART receive datapath that supersedes the fixed 8-bit receive shift register. It synchronises the serial line, detects and qualifies the start bit, and oversamples each bit at mid-period. It shifts DATA_BITS data bits LSB-first, checks optional parity and the stop bits, and delivers the frame to a holding register read over the 32-bit tri-state CPU data bus. It sits between the baud-rate generator (which supplies SampleTick) and the UART bus interface.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_sync.sv | 22 ++
 rtl/uart_rx_deserializer.sv | 171 +++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state names, parity modes and
// the tick-counter width helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic int tick_width(input int oversample);
        return $clog2(oversample);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an idle-high asynchronous line (serial data, CTS).
module uart_rx_sync (
    input  logic Clock,
    input  logic Reset,
    input  logic line,
    output logic synced
);

    logic meta;

    // Both flops reset to 1 so a quiet line never looks like a start bit.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            meta   <= 1'b1;
            synced <= 1'b1;
        end else begin
            meta   <= line;
            synced <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_deserializer.sv
// Parametrised UART receiver: start-bit qualification, mid-bit oversampling,
// parity/stop checking and a CPU-readable holding register on a tri-state bus.
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        SampleTick,
    input  logic        SerIn,
    input  logic        OE,
    input  logic        Ack,
    output logic [31:0] Dout,
    output logic        Ready,
    output logic        FrameErr,
    output logic        ParityErr,
    output logic        Overrun
);

    localparam int             TW        = tick_width(OVERSAMPLE);
    localparam logic [TW-1:0]  TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0]  TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);

    rx_state_t            state;
    rx_state_t            state_next;
    logic                 rx_s;
    logic [TW-1:0]        tick_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] holding;
    logic                 armed;
    logic                 stop_err;
    logic                 par_err;
    logic                 mid_tick;
    logic                 end_tick;
    logic                 start_seen;
    logic                 start_ok;
    logic                 data_sample;
    logic                 data_last;
    logic                 parity_sample;
    logic                 stop_sample;
    logic                 frame_done;
    logic                 frame_err_new;

    uart_rx_sync u_sync (
        .Clock  (Clock),
        .Reset  (Reset),
        .line   (SerIn),
        .synced (rx_s)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start_seen)    state_next = ST_START;
            ST_START:  if (mid_tick)      state_next = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:   if (data_last)     state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (parity_sample) state_next = ST_STOP;
            ST_STOP:   if (frame_done)    state_next = ST_IDLE;
            default:                      state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mid_tick      = SampleTick && (tick_cnt == TICK_MID);
        end_tick      = SampleTick && (tick_cnt == TICK_LAST);
        start_seen    = (state == ST_IDLE) && SampleTick && !rx_s && armed;
        start_ok      = (state == ST_START) && mid_tick && !rx_s;
        data_sample   = (state == ST_DATA) && end_tick;
        data_last     = data_sample && (bit_cnt == DATA_LAST);
        parity_sample = (state == ST_PARITY) && end_tick;
        stop_sample   = (state == ST_STOP) && end_tick;
        frame_done    = stop_sample && (bit_cnt == STOP_LAST);
        frame_err_new = stop_err || !rx_s;
    end

    // Counters restart on every state change; the tick counter wraps naturally
    // at OVERSAMPLE, so consecutive bits need no explicit clear.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
        end else if (state_next != state) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            if (SampleTick && (state != ST_IDLE)) begin
                tick_cnt <= tick_cnt + TW'(1);
            end
            if (data_sample || stop_sample) begin
                bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

    // armed blocks retriggering on a line left low after a bad stop bit until
    // the receiver has seen it high again while idle.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            shreg    <= '0;
            armed    <= 1'b1;
            stop_err <= 1'b0;
            par_err  <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && SampleTick && rx_s) begin
                armed <= 1'b1;
            end
            if (frame_done) begin
                armed <= rx_s;
            end
            if (start_ok) begin
                stop_err <= 1'b0;
                par_err  <= 1'b0;
            end
            if (data_sample) begin
                shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            end
            if (parity_sample) begin
                par_err <= (PARITY == PAR_ODD) ? !(^{shreg, rx_s}) : (^{shreg, rx_s});
            end
            if (stop_sample && !rx_s) begin
                stop_err <= 1'b1;
            end
        end
    end

    // An Ack coinciding with completion frees the register for the new frame.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            holding   <= '0;
            Ready     <= 1'b0;
            FrameErr  <= 1'b0;
            ParityErr <= 1'b0;
            Overrun   <= 1'b0;
        end else if (frame_done) begin
            if (!Ready || Ack) begin
                holding   <= shreg;
                FrameErr  <= frame_err_new;
                ParityErr <= par_err;
                Ready     <= 1'b1;
                if (Ack) begin
                    Overrun <= 1'b0;
                end
            end else begin
                Overrun <= 1'b1;
            end
        end else if (Ack && Ready) begin
            Ready     <= 1'b0;
            FrameErr  <= 1'b0;
            ParityErr <= 1'b0;
            Overrun   <= 1'b0;
        end
    end

    assign Dout = OE ? {{(32 - DATA_BITS){1'b0}}, holding} : 'z;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench for uart_rx_deserializer: an 8N1 instance and a 7E2 instance
// are driven with directed and random frames, checked by a decoupled monitor.
module tb_uart_rx_deserializer;

    localparam int OS  = 16;
    localparam int NB0 = 8;
    localparam int NS0 = 1;
    localparam int NB1 = 7;
    localparam int NS1 = 2;

    typedef struct {
        logic [8:0] data;
        bit         ferr;
        bit         perr;
    } exp_t;

    logic        Clock      = 1'b0;
    logic        Reset      = 1'b1;
    logic        SampleTick = 1'b1;
    logic [1:0]  ser        = 2'b11;
    logic [1:0]  oe         = 2'b11;
    logic [1:0]  ack        = 2'b00;
    logic [1:0]  ready;
    logic [1:0]  ferr;
    logic [1:0]  perr;
    logic [1:0]  ovr;
    wire  [31:0] dout0;
    wire  [31:0] dout1;

    bit   tick_rand = 1'b0;
    int   n_vec     = 0;
    int   n_fail    = 0;
    exp_t q0[$];
    exp_t q1[$];
    bit   mdl_ready[2];
    bit   mdl_ovr[2];

    // Pull-ups make an undriven bus read as all ones, so OE=0 is observable.
    for (genvar i = 0; i < 32; i++) begin : g_pull
        pullup (dout0[i]);
        pullup (dout1[i]);
    end

    uart_rx_deserializer #(.DATA_BITS(NB0), .OVERSAMPLE(OS), .PARITY(0), .STOP_BITS(NS0)) dut (
        .Clock(Clock), .Reset(Reset), .SampleTick(SampleTick), .SerIn(ser[0]), .OE(oe[0]),
        .Ack(ack[0]), .Dout(dout0), .Ready(ready[0]), .FrameErr(ferr[0]),
        .ParityErr(perr[0]), .Overrun(ovr[0])
    );

    uart_rx_deserializer #(.DATA_BITS(NB1), .OVERSAMPLE(OS), .PARITY(2), .STOP_BITS(NS1)) dut_par (
        .Clock(Clock), .Reset(Reset), .SampleTick(SampleTick), .SerIn(ser[1]), .OE(oe[1]),
        .Ack(ack[1]), .Dout(dout1), .Ready(ready[1]), .FrameErr(ferr[1]),
        .ParityErr(perr[1]), .Overrun(ovr[1])
    );

    always #5 Clock = ~Clock;

    initial begin
        forever begin
            @(negedge Clock);
            SampleTick = tick_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    function automatic logic [31:0] dout_of(input int d);
        return (d == 0) ? dout0 : dout1;
    endfunction

    function automatic int q_size(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_flags(input int d, input string tag);
        check_output($sformatf("%s_ready%0d", tag, d), 32'(ready[d]), 32'(mdl_ready[d]));
        check_output($sformatf("%s_overrun%0d", tag, d), 32'(ovr[d]), 32'(mdl_ovr[d]));
    endtask

    task automatic pop_and_compare(input int d);
        exp_t e;
        if (q_size(d) == 0) begin
            n_vec++;
            n_fail++;
            $display("[TB] FAIL unexpected_frame%0d: got dout %h, expected no frame", d, dout_of(d));
        end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            check_output($sformatf("dout%0d", d), dout_of(d), oe[d] ? 32'(e.data) : 32'hFFFF_FFFF);
            check_output($sformatf("frame_err%0d", d), 32'(ferr[d]), 32'(e.ferr));
            check_output($sformatf("parity_err%0d", d), 32'(perr[d]), 32'(e.perr));
        end
    endtask

    // A new frame is presented when Ready rises, or when Ready stays high
    // across an Ack (completion coinciding with the Ack).
    initial begin
        bit rdy_prev[2];
        bit ack_prev[2];
        rdy_prev = '{0, 0};
        ack_prev = '{0, 0};
        forever begin
            @(negedge Clock);
            for (int d = 0; d < 2; d++) begin
                if (!Reset && ready[d] && (!rdy_prev[d] || ack_prev[d])) begin
                    pop_and_compare(d);
                end
                rdy_prev[d] = ready[d] && !Reset;
                ack_prev[d] = ack[d];
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        int c;
        c = 0;
        while (c < n) begin
            @(posedge Clock);
            if (SampleTick) c++;
            #1;
        end
    endtask

    // ack_at > 0 raises Ack so that it is sampled on that Clock edge after the
    // falling start edge (only meaningful with SampleTick held high).
    task automatic apply_frame(input int d, input logic [8:0] data, input bit pbit,
                               input logic [1:0] stops, input int ack_at, input bit hold_low);
        int         nb      = (d == 0) ? NB0 : NB1;
        int         ns      = (d == 0) ? NS0 : NS1;
        bit         use_par = (d == 1);
        logic [8:0] m;
        bit         line_bits[$];
        exp_t       e;
        int         clk;
        m = data & 9'((1 << nb) - 1);
        line_bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) line_bits.push_back(m[i]);
        if (use_par) line_bits.push_back(pbit);
        for (int i = 0; i < ns; i++) line_bits.push_back(stops[i]);
        line_bits.push_back(!hold_low);
        e.data = m;
        e.ferr = (stops[0] == 1'b0) || ((ns == 2) && (stops[1] == 1'b0));
        e.perr = use_par && ((($countones(m) + int'(pbit)) % 2) == 1);
        if ((ack_at > 0) || !mdl_ready[d]) begin
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
            if (ack_at > 0) mdl_ovr[d] = 1'b0;
            mdl_ready[d] = 1'b1;
        end else begin
            mdl_ovr[d] = 1'b1;
        end
        clk = 0;
        foreach (line_bits[b]) begin
            int cnt;
            cnt = 0;
            ser[d] = line_bits[b];
            while (cnt < OS) begin
                @(posedge Clock);
                clk++;
                if (SampleTick) cnt++;
                #1;
                ack[d] = (ack_at > 0) && (clk == ack_at - 1);
            end
        end
        ack[d] = 1'b0;
    endtask

    task automatic wait_drain(input int d);
        int n;
        n = 0;
        while ((q_size(d) > 0) && (n < 4 * OS)) begin
            @(negedge Clock);
            n++;
        end
        n_vec++;
        if (q_size(d) > 0) begin
            n_fail++;
            $display("[TB] FAIL drain%0d: got %0d frames pending, expected 0", d, q_size(d));
            if (d == 0) q0.delete();
            else        q1.delete();
        end
        idle(1);
    endtask

    task automatic do_ack(input int d);
        ack[d] = 1'b1;
        idle(1);
        ack[d] = 1'b0;
        if (mdl_ready[d]) begin
            mdl_ready[d] = 1'b0;
            mdl_ovr[d]   = 1'b0;
        end
        check_flags(d, "ack");
        check_output($sformatf("ack_errs%0d", d), {30'd0, ferr[d], perr[d]}, 32'd0);
    endtask

    initial begin
        mdl_ready = '{0, 0};
        mdl_ovr   = '{0, 0};
        idle(3);
        check_output("reset_flags", {24'd0, ready, ferr, perr, ovr}, 32'd0);
        check_output("reset_dout", dout0, 32'd0);
        Reset = 1'b0;
        idle(4);

        apply_frame(0, 9'hA5, 1'b0, 2'b11, 0, 1'b0);
        wait_drain(0);
        check_flags(0, "a5");
        check_output("a5_dout", dout0, 32'h0000_00A5);
        do_ack(0);

        ser = 2'b00;
        wait_ticks(OS / 4);
        ser = 2'b11;
        wait_ticks(3 * OS);
        check_flags(0, "glitch");
        check_flags(1, "glitch");
        check_output("glitch_flags", {28'd0, ferr, perr}, 32'd0);

        apply_frame(1, 9'h55, 1'b1, 2'b11, 0, 1'b0);
        wait_drain(1);
        check_output("par_bad_dout", dout1, 32'h0000_0055);
        do_ack(1);
        apply_frame(1, 9'h55, 1'b0, 2'b11, 0, 1'b0);
        wait_drain(1);
        do_ack(1);
        apply_frame(1, 9'h2B, 1'b0, 2'b01, 0, 1'b0);
        wait_drain(1);
        do_ack(1);

        apply_frame(0, 9'h3C, 1'b0, 2'b00, 0, 1'b1);
        wait_ticks(12 * OS);
        ser[0] = 1'b1;
        wait_ticks(2 * OS);
        wait_drain(0);
        check_flags(0, "held_low");
        check_output("held_low_dout", dout0, 32'h0000_003C);
        do_ack(0);

        apply_frame(0, 9'h11, 1'b0, 2'b11, 0, 1'b0);
        wait_drain(0);
        apply_frame(0, 9'h22, 1'b0, 2'b11, 0, 1'b0);
        idle(2);
        check_flags(0, "overrun");
        check_output("overrun_dout", dout0, 32'h0000_0011);
        do_ack(0);
        apply_frame(0, 9'h44, 1'b0, 2'b11, 0, 1'b0);
        wait_drain(0);
        // Final stop sample: 2 sync flops + detect edge, half a bit, then one bit per sample.
        apply_frame(0, 9'h33, 1'b0, 2'b11, 3 + OS / 2 + OS * (NB0 + NS0), 1'b0);
        wait_drain(0);
        check_flags(0, "ack_same");
        check_output("ack_same_dout", dout0, 32'h0000_0033);
        do_ack(0);

        oe[0]  = 1'b0;
        ser[0] = 1'b0;
        wait_ticks(3 * OS);
        Reset = 1'b1;
        idle(1);
        check_output("mid_reset_ready", 32'(ready[0]), 32'd0);
        check_output("mid_reset_hiz", dout0, 32'hFFFF_FFFF);
        ser[0] = 1'b1;
        idle(2);
        Reset = 1'b0;
        mdl_ready = '{0, 0};
        mdl_ovr   = '{0, 0};
        idle(4);
        check_flags(0, "post_reset");
        apply_frame(0, 9'h7E, 1'b0, 2'b11, 0, 1'b0);
        wait_drain(0);
        check_output("oe_off_dout", dout0, 32'hFFFF_FFFF);
        oe[0] = 1'b1;
        #1;
        check_output("oe_on_dout", dout0, 32'h0000_007E);
        do_ack(0);

        tick_rand = 1'b1;
        for (int it = 0; it < 24; it++) begin
            int         d;
            logic [8:0] data;
            logic [1:0] stops;
            d     = $urandom_range(0, 1);
            data  = 9'($urandom);
            stops = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b11;
            apply_frame(d, data, 1'($urandom), stops, 0, 1'b0);
            wait_drain(d);
            check_flags(d, "rand");
            if ($urandom_range(0, 3) != 0) do_ack(d);
        end
        tick_rand = 1'b0;
        idle(2);
        for (int d = 0; d < 2; d++) begin
            if (mdl_ready[d]) do_ack(d);
        end
        check_output("queues_empty", 32'(q0.size() + q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_vec++;
        n_fail++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
